// File: rtl/div_pkg.sv
// Shared types and helpers for the sequential restoring divider.
package div_pkg;

  // Controller states: waiting for a request, iterating, presenting the result.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } div_state_t;

  // Width of the iteration counter, which must hold the value N-1.
  // It is kept at least one bit wide so that it stays a legal vector.
  function automatic int cnt_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/div_step.sv
// One restoring-division step: shift the next dividend bit into the partial
// remainder, and subtract the divisor if the result is at least the divisor.
module div_step #(
  parameter int N = 4
) (
  input  logic [N:0]   rem_i,
  input  logic         bit_i,
  input  logic [N-1:0] b_i,
  output logic [N:0]   rem_o,
  output logic         q_o
);

  logic [N:0] rem_sh;
  logic [N:0] rem_sub;
  logic       ge;

  // Shift, compare and conditionally subtract.
  always_comb begin
    rem_sh  = {rem_i[N-1:0], bit_i};
    rem_sub = rem_sh - {1'b0, b_i};
    // The top remainder bit is always 0 because the remainder stays below B.
    // If it were ever set, the shifted value would exceed any divisor, so it
    // forces a subtract.
    ge      = rem_i[N] | (rem_sh >= {1'b0, b_i});
    q_o     = ge;
    rem_o   = ge ? rem_sub : rem_sh;
  end

endmodule

// File: rtl/seq_div.sv
// Sequential restoring divider: 2N-bit dividend / N-bit divisor, one quotient
// bit per clock, with quotient-overflow (v) and divide-by-zero (dz) flags.
module seq_div
  import div_pkg::*;
#(
  parameter int N = 4  // must be at least 2
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           start,
  input  logic [2*N-1:0] A,
  input  logic [N-1:0]   B,
  output logic [N-1:0]   Q,
  output logic [N-1:0]   R,
  output logic           v,
  output logic           dz,
  output logic           busy,
  output logic           done
);

  localparam int CW = cnt_w(N);

  div_state_t    state_q, state_d;
  logic [N:0]    rem_q, rem_d;     // partial remainder
  logic [N-1:0]  sh_q, sh_d;       // dividend bits out at the top, quotient bits in at the bottom
  logic [N-1:0]  b_q, b_d;         // captured divisor
  logic [CW-1:0] cnt_q, cnt_d;     // steps remaining minus one
  logic [N-1:0]  quo_q, quo_d;
  logic [N-1:0]  rmd_q, rmd_d;
  logic          v_q, v_d;
  logic          dz_q, dz_d;

  logic [N:0]    step_rem;
  logic          step_qbit;

  div_step #(.N(N)) u_step (
    .rem_i (rem_q),
    .bit_i (sh_q[N-1]),
    .b_i   (b_q),
    .rem_o (step_rem),
    .q_o   (step_qbit)
  );

  // Next-state and datapath control; everything holds unless changed below.
  always_comb begin
    state_d = state_q;
    rem_d   = rem_q;
    sh_d    = sh_q;
    b_d     = b_q;
    cnt_d   = cnt_q;
    quo_d   = quo_q;
    rmd_d   = rmd_q;
    v_d     = v_q;
    dz_d    = dz_q;

    case (state_q)
      IDLE: begin
        if (start) begin
          b_d   = B;
          quo_d = '0;
          rmd_d = '0;
          v_d   = 1'b0;
          dz_d  = 1'b0;
          if (B == '0) begin
            dz_d    = 1'b1;
            quo_d   = '1;
            state_d = DONE;
          end else if (A[2*N-1:N] >= B) begin
            // The quotient needs more than N bits: report overflow at once.
            v_d     = 1'b1;
            quo_d   = '1;
            state_d = DONE;
          end else begin
            rem_d   = {1'b0, A[2*N-1:N]};
            sh_d    = A[N-1:0];
            cnt_d   = CW'(N - 1);
            state_d = RUN;
          end
        end
      end

      RUN: begin
        rem_d = step_rem;
        sh_d  = {sh_q[N-2:0], step_qbit};
        if (cnt_q == '0) begin
          quo_d   = {sh_q[N-2:0], step_qbit};
          rmd_d   = step_rem[N-1:0];
          state_d = DONE;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end

      DONE: begin
        // start is deliberately not looked at here; it is not queued.
        state_d = IDLE;
      end

      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      rem_q   <= '0;
      sh_q    <= '0;
      b_q     <= '0;
      cnt_q   <= '0;
      quo_q   <= '0;
      rmd_q   <= '0;
      v_q     <= 1'b0;
      dz_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      rem_q   <= rem_d;
      sh_q    <= sh_d;
      b_q     <= b_d;
      cnt_q   <= cnt_d;
      quo_q   <= quo_d;
      rmd_q   <= rmd_d;
      v_q     <= v_d;
      dz_q    <= dz_d;
    end
  end

  assign Q    = quo_q;
  assign R    = rmd_q;
  assign v    = v_q;
  assign dz   = dz_q;
  assign busy = (state_q == RUN);
  assign done = (state_q == DONE);

endmodule

// File: tb/tb_seq_div.sv
// Self-checking bench for seq_div at N=4 and N=8 against an arithmetic model.
module tb_seq_div;

  logic clk = 1'b0;
  logic rst = 1'b1;

  logic       start4 = 1'b0;
  logic [7:0] a4 = '0;
  logic [3:0] b4 = '0;
  logic [3:0] q4, r4;
  logic       v4, dz4, busy4, done4;

  logic        start8 = 1'b0;
  logic [15:0] a8 = '0;
  logic [7:0]  b8 = '0;
  logic [7:0]  q8, r8;
  logic        v8, dz8, busy8, done8;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  seq_div #(.N(4)) dut4 (
    .clk(clk), .rst(rst), .start(start4), .A(a4), .B(b4),
    .Q(q4), .R(r4), .v(v4), .dz(dz4), .busy(busy4), .done(done4)
  );

  seq_div #(.N(8)) dut8 (
    .clk(clk), .rst(rst), .start(start8), .A(a8), .B(b8),
    .Q(q8), .R(r8), .v(v8), .dz(dz8), .busy(busy8), .done(done8)
  );

  // Reference: plain integer division with the flag rules layered on top.
  function automatic void ref_div(input int unsigned a, input int unsigned b, input int n,
                                  output int unsigned q, output int unsigned r,
                                  output logic v, output logic dz);
    int unsigned ones;
    ones = (32'd1 << n) - 1;
    v = 1'b0; dz = 1'b0;
    if (b == 0) begin
      dz = 1'b1; q = ones; r = 0;
    end else if (a / b > ones) begin
      v = 1'b1; q = ones; r = 0;
    end else begin
      q = a / b; r = a % b;
    end
  endfunction

  // Issue one N=4 divide and wait (bounded) for done; returns latency and busy cycles.
  task automatic run4(input logic [7:0] a, input logic [3:0] b, output int lat, output int bcnt);
    @(negedge clk); a4 = a; b4 = b; start4 = 1'b1;
    @(negedge clk); start4 = 1'b0; a4 = 8'($urandom); b4 = 4'($urandom);
    lat = 1; bcnt = 0;
    while (done4 !== 1'b1 && lat < 40) begin
      if (busy4 === 1'b1) bcnt++;
      @(negedge clk); lat++;
    end
    checks++;
    if (done4 !== 1'b1) begin
      errors++; $display("FAIL run4_timeout: done=%b required 1 (A=%0d B=%0d)", done4, a, b);
    end
    checks++;
    if (busy4 !== 1'b0) begin
      errors++; $display("FAIL run4_busy_with_done: busy=%b required 0", busy4);
    end
  endtask

  task automatic run8(input logic [15:0] a, input logic [7:0] b, output int lat, output int bcnt);
    @(negedge clk); a8 = a; b8 = b; start8 = 1'b1;
    @(negedge clk); start8 = 1'b0; a8 = 16'($urandom); b8 = 8'($urandom);
    lat = 1; bcnt = 0;
    while (done8 !== 1'b1 && lat < 40) begin
      if (busy8 === 1'b1) bcnt++;
      @(negedge clk); lat++;
    end
    checks++;
    if (done8 !== 1'b1) begin
      errors++; $display("FAIL run8_timeout: done=%b required 1 (A=%0d B=%0d)", done8, a, b);
    end
    checks++;
    if (busy8 !== 1'b0) begin
      errors++; $display("FAIL run8_busy_with_done: busy=%b required 0", busy8);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    checks++;
    if ({q4, r4, v4, dz4, busy4, done4} !== 12'd0) begin
      errors++; $display("FAIL reset4: Q=%0d R=%0d v=%b dz=%b busy=%b done=%b required all 0",
                         q4, r4, v4, dz4, busy4, done4);
    end
    checks++;
    if ({q8, r8, v8, dz8, busy8, done8} !== 20'd0) begin
      errors++; $display("FAIL reset8: Q=%0d R=%0d v=%b dz=%b busy=%b done=%b required all 0",
                         q8, r8, v8, dz8, busy8, done8);
    end
    rst = 1'b0;
  endtask

  // Directed cases: normal, exact, overflow and divide-by-zero.
  task automatic test_directed();
    logic [7:0] ta [4] = '{8'd100, 8'd225, 8'd255, 8'd37};
    logic [3:0] tb [4] = '{4'd7, 4'd15, 4'd15, 4'd0};
    int lat, bcnt, elat, ebusy;
    int unsigned eq, er;
    logic ev, edz;
    for (int i = 0; i < 4; i++) begin
      run4(ta[i], tb[i], lat, bcnt);
      ref_div(ta[i], tb[i], 4, eq, er, ev, edz);
      elat  = (ev || edz) ? 1 : 5;
      ebusy = (ev || edz) ? 0 : 4;
      checks++;
      if (32'(q4) !== eq || 32'(r4) !== er) begin
        errors++; $display("FAIL directed_qr %0d/%0d: Q=%0d R=%0d required Q=%0d R=%0d",
                           ta[i], tb[i], q4, r4, eq, er);
      end
      checks++;
      if (v4 !== ev || dz4 !== edz) begin
        errors++; $display("FAIL directed_flags %0d/%0d: v=%b dz=%b required v=%b dz=%b",
                           ta[i], tb[i], v4, dz4, ev, edz);
      end
      checks++;
      if (lat != elat || bcnt != ebusy) begin
        errors++; $display("FAIL directed_timing %0d/%0d: done at +%0d busy %0d cycles required +%0d and %0d",
                           ta[i], tb[i], lat, bcnt, elat, ebusy);
      end
    end
  endtask

  // start during RUN and during DONE must be ignored; results hold afterwards.
  task automatic test_start_ignored();
    int lat;
    int unsigned eq, er;
    logic ev, edz;
    ref_div(100, 7, 4, eq, er, ev, edz);
    @(negedge clk); a4 = 8'd100; b4 = 4'd7; start4 = 1'b1;
    @(negedge clk); a4 = 8'd200; b4 = 4'd3; start4 = 1'b1;
    @(negedge clk); start4 = 1'b0;
    lat = 2;
    while (done4 !== 1'b1 && lat < 40) begin
      @(negedge clk); lat++;
    end
    checks++;
    if (done4 !== 1'b1 || lat != 5) begin
      errors++; $display("FAIL ignore_latency: done=%b at +%0d required 1 at +5", done4, lat);
    end
    checks++;
    if (32'(q4) !== eq || 32'(r4) !== er || v4 !== 1'b0) begin
      errors++; $display("FAIL ignore_result: Q=%0d R=%0d v=%b required Q=%0d R=%0d v=0", q4, r4, v4, eq, er);
    end
    a4 = 8'd50; b4 = 4'd5; start4 = 1'b1;
    @(negedge clk); start4 = 1'b0;
    checks++;
    if (busy4 !== 1'b0 || done4 !== 1'b0) begin
      errors++; $display("FAIL ignore_in_done: busy=%b done=%b required 0 0", busy4, done4);
    end
    repeat (3) @(negedge clk);
    checks++;
    if (32'(q4) !== eq || 32'(r4) !== er || busy4 !== 1'b0) begin
      errors++; $display("FAIL hold_after_done: Q=%0d R=%0d busy=%b required Q=%0d R=%0d busy=0",
                         q4, r4, busy4, eq, er);
    end
  endtask

  // Reset in the second RUN cycle aborts silently; the next divide is clean.
  task automatic test_reset_mid_run();
    int ndone, nbusy, lat, bcnt;
    int unsigned eq, er;
    logic ev, edz;
    @(negedge clk); a4 = 8'd100; b4 = 4'd7; start4 = 1'b1;
    @(negedge clk); start4 = 1'b0;
    @(negedge clk); rst = 1'b1; start4 = 1'b1;
    @(negedge clk);
    checks++;
    if ({q4, r4, v4, dz4, busy4, done4} !== 12'd0) begin
      errors++; $display("FAIL reset_mid_run: Q=%0d R=%0d v=%b dz=%b busy=%b done=%b required all 0",
                         q4, r4, v4, dz4, busy4, done4);
    end
    rst = 1'b0; start4 = 1'b0;
    ndone = 0; nbusy = 0;
    repeat (8) begin
      @(negedge clk);
      if (done4 === 1'b1) ndone++;
      if (busy4 === 1'b1) nbusy++;
    end
    checks++;
    if (ndone != 0 || nbusy != 0) begin
      errors++; $display("FAIL abort_quiet: done seen %0d busy seen %0d required 0 0", ndone, nbusy);
    end
    run4(8'd100, 4'd7, lat, bcnt);
    ref_div(100, 7, 4, eq, er, ev, edz);
    checks++;
    if (32'(q4) !== eq || 32'(r4) !== er || lat != 5 || bcnt != 4) begin
      errors++; $display("FAIL after_reset: Q=%0d R=%0d lat=%0d busy=%0d required Q=%0d R=%0d lat=5 busy=4",
                         q4, r4, lat, bcnt, eq, er);
    end
  endtask

  // Multiply->divide loopback and random divides at N=4.
  task automatic test_random4();
    int lat, bcnt;
    int unsigned a, b, eq, er;
    logic ev, edz;
    for (int i = 0; i < 20; i++) begin
      a = $urandom_range(15, 0); b = $urandom_range(15, 1);
      run4(8'(a * b), 4'(b), lat, bcnt);
      checks++;
      if (32'(q4) !== a || r4 !== 4'd0 || v4 !== 1'b0 || dz4 !== 1'b0) begin
        errors++; $display("FAIL loop4 %0d*%0d: Q=%0d R=%0d v=%b dz=%b required Q=%0d R=0 v=0 dz=0",
                           a, b, q4, r4, v4, dz4, a);
      end
    end
    for (int i = 0; i < 30; i++) begin
      a = $urandom_range(255, 0); b = $urandom_range(15, 0);
      run4(8'(a), 4'(b), lat, bcnt);
      ref_div(a, b, 4, eq, er, ev, edz);
      checks++;
      if (32'(q4) !== eq || 32'(r4) !== er || v4 !== ev || dz4 !== edz ||
          lat != ((ev || edz) ? 1 : 5)) begin
        errors++; $display("FAIL rand4 %0d/%0d: Q=%0d R=%0d v=%b dz=%b lat=%0d required Q=%0d R=%0d v=%b dz=%b",
                           a, b, q4, r4, v4, dz4, lat, eq, er, ev, edz);
      end
    end
  endtask

  // Same at N=8.
  task automatic test_random8();
    int lat, bcnt;
    int unsigned a, b, eq, er;
    logic ev, edz;
    for (int i = 0; i < 20; i++) begin
      a = $urandom_range(255, 0); b = $urandom_range(255, 1);
      run8(16'(a * b), 8'(b), lat, bcnt);
      checks++;
      if (32'(q8) !== a || r8 !== 8'd0 || v8 !== 1'b0 || dz8 !== 1'b0 || lat != 9 || bcnt != 8) begin
        errors++; $display("FAIL loop8 %0d*%0d: Q=%0d R=%0d v=%b dz=%b lat=%0d busy=%0d required Q=%0d R=0 lat=9 busy=8",
                           a, b, q8, r8, v8, dz8, lat, bcnt, a);
      end
    end
    for (int i = 0; i < 30; i++) begin
      a = $urandom_range(65535, 0);
      b = (i % 10 == 0) ? 0 : $urandom_range(255, 1);
      run8(16'(a), 8'(b), lat, bcnt);
      ref_div(a, b, 8, eq, er, ev, edz);
      checks++;
      if (32'(q8) !== eq || 32'(r8) !== er || v8 !== ev || dz8 !== edz ||
          lat != ((ev || edz) ? 1 : 9)) begin
        errors++; $display("FAIL rand8 %0d/%0d: Q=%0d R=%0d v=%b dz=%b lat=%0d required Q=%0d R=%0d v=%b dz=%b",
                           a, b, q8, r8, v8, dz8, lat, eq, er, ev, edz);
      end
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_start_ignored();
    test_reset_mid_run();
    test_random4();
    test_random8();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  // Absolute time limit so the run can never hang.
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog expired");
  end

endmodule
